// File: rtl/id_ex_ctrl_reg.sv
// id_ex_ctrl_reg
// Decode-to-execute pipeline register. It captures the decoder control
// bundle, register indices and operands each cycle. It also detects
// load-use hazards against the instruction in E and inserts bubbles.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   *D inputs                  decoder control, indices, operands, ValidD
//   FlushE                     kill the instruction entering E (load bubble)
//   StallE                     hold E contents (downstream not ready)
//   *E outputs                 registered copy of the D bundle, ValidE
//   StallD                     combinational hold request to IF/ID
//   BubbleCnt                  saturating count of inserted bubbles
module id_ex_ctrl_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic                  BranchD,
  input  logic                  ALUSrcD,
  input  logic [1:0]            ALUOpD,
  input  logic                  PcOpD,
  input  logic [4:0]            Rs1D,
  input  logic [4:0]            Rs2D,
  input  logic [4:0]            RdD,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [DATA_WIDTH-1:0] ImmExtD,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic                  ValidD,
  input  logic                  FlushE,
  input  logic                  StallE,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic [1:0]            ALUOpE,
  output logic                  PcOpE,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic [4:0]            RdE,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic                  ValidE,
  output logic                  StallD,
  output logic [CNT_WIDTH-1:0]  BubbleCnt
);

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            alu_op;
    logic                  pc_op;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] pc;
    logic                  valid;
  } e_bundle_t;

  localparam logic [1:0] RES_MEM = 2'b01;

  e_bundle_t             e_q, e_d, d_in;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic                  load_use;
  logic                  bubble;

  always_comb begin
    d_in            = '0;
    d_in.reg_write  = RegWriteD;
    d_in.result_src = ResultSrcD;
    d_in.mem_write  = MemWriteD;
    d_in.branch     = BranchD;
    d_in.alu_src    = ALUSrcD;
    d_in.alu_op     = ALUOpD;
    d_in.pc_op      = PcOpD;
    d_in.rs1        = Rs1D;
    d_in.rs2        = Rs2D;
    d_in.rd         = RdD;
    d_in.rd1        = RD1D;
    d_in.rd2        = RD2D;
    d_in.imm_ext    = ImmExtD;
    d_in.pc         = PCD;
    d_in.valid      = ValidD;
  end

  // Rs2 is compared even for instructions that do not read it; the
  // occasional false stall is cheaper than decoding operand usage here.
  always_comb begin
    load_use = e_q.valid && e_q.reg_write && (e_q.result_src == RES_MEM) &&
               (e_q.rd != 5'd0) && ((e_q.rd == Rs1D) || (e_q.rd == Rs2D)) &&
               ValidD;
    StallD   = load_use || StallE;
  end

  // Flush beats hold; hold suppresses the load-use bubble because the
  // load stays in E and the hazard persists until E moves on.
  always_comb begin
    bubble       = FlushE || (!StallE && load_use);
    e_d          = e_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bubble) begin
      e_d = '0;
      if (!(&bubble_cnt_q)) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else if (!StallE) begin
      e_d = d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q          <= '0;
      bubble_cnt_q <= '0;
    end else begin
      e_q          <= e_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign RegWriteE  = e_q.reg_write;
  assign ResultSrcE = e_q.result_src;
  assign MemWriteE  = e_q.mem_write;
  assign BranchE    = e_q.branch;
  assign ALUSrcE    = e_q.alu_src;
  assign ALUOpE     = e_q.alu_op;
  assign PcOpE      = e_q.pc_op;
  assign Rs1E       = e_q.rs1;
  assign Rs2E       = e_q.rs2;
  assign RdE        = e_q.rd;
  assign RD1E       = e_q.rd1;
  assign RD2E       = e_q.rd2;
  assign ImmExtE    = e_q.imm_ext;
  assign PCE        = e_q.pc;
  assign ValidE     = e_q.valid;
  assign BubbleCnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl_reg.sv
// tb_id_ex_ctrl_reg
// Directed bench for id_ex_ctrl_reg with a 2-bit bubble counter so that
// saturation is reachable.
module tb_id_ex_ctrl_reg;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWriteD, MemWriteD, BranchD, ALUSrcD, PcOpD, ValidD;
  logic [1:0]    ResultSrcD, ALUOpD;
  logic [4:0]    Rs1D, Rs2D, RdD;
  logic [DW-1:0] RD1D, RD2D, ImmExtD, PCD;
  logic          FlushE, StallE;
  logic          RegWriteE, MemWriteE, BranchE, ALUSrcE, PcOpE, ValidE, StallD;
  logic [1:0]    ResultSrcE, ALUOpE;
  logic [4:0]    Rs1E, Rs2E, RdE;
  logic [DW-1:0] RD1E, RD2E, ImmExtE, PCE;
  logic [CW-1:0] BubbleCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_ctrl_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUOpD(ALUOpD), .PcOpD(PcOpD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .ValidD(ValidD), .FlushE(FlushE), .StallE(StallE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUOpE(ALUOpE), .PcOpE(PcOpE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .ValidE(ValidE), .StallD(StallD), .BubbleCnt(BubbleCnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; BranchD = 0; ALUSrcD = 0;
    ALUOpD = 0; PcOpD = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
    RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; ValidD = 0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    clear_d();
    RegWriteD = 1; ResultSrcD = 2'b01; RdD = rd; ValidD = 1; PCD = 32'h50;
  endtask

  task automatic set_alu(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [DW-1:0] pc);
    clear_d();
    RegWriteD = 1; ALUOpD = 2'b10; Rs1D = rs1; Rs2D = rs2; RdD = rd;
    PCD = pc; ValidD = 1;
  endtask

  initial begin
    clear_d();
    FlushE = 0; StallE = 0; rst = 1;
    step(); step();
    chk("rst_valid", ValidE, 0);
    chk("rst_regwrite", RegWriteE, 0);
    chk("rst_pc", PCE, 0);
    chk("rst_cnt", BubbleCnt, 0);

    // 1: capture
    clear_d();
    RegWriteD = 1; ALUOpD = 2'b10; RdD = 5; RD1D = 32'h11; RD2D = 32'h22;
    PCD = 32'h100; ValidD = 1; ImmExtD = 32'hABC; Rs1D = 3; Rs2D = 4;
    BranchD = 1; ALUSrcD = 1; PcOpD = 1;
    rst = 0;
    step();
    chk("cap_regwrite", RegWriteE, 1);
    chk("cap_aluop", ALUOpE, 2'b10);
    chk("cap_rd", RdE, 5);
    chk("cap_rd1", RD1E, 32'h11);
    chk("cap_rd2", RD2E, 32'h22);
    chk("cap_imm", ImmExtE, 32'hABC);
    chk("cap_pc", PCE, 32'h100);
    chk("cap_rs", {Rs1E, Rs2E}, {5'd3, 5'd4});
    chk("cap_misc", {BranchE, ALUSrcE, PcOpE, MemWriteE, ResultSrcE}, 6'b111000);
    chk("cap_valid", ValidE, 1);
    chk("cap_cnt", BubbleCnt, 0);

    // 2: load-use
    set_load(7);
    step();
    set_alu(7, 0, 8, 32'h104);
    RD1D = 32'h33;
    #1 chk("lu_stalld", StallD, 1);
    step();
    chk("lu_bub_valid", ValidE, 0);
    chk("lu_bub_ctrl", {RegWriteE, ResultSrcE, MemWriteE, ALUOpE}, 0);
    chk("lu_bub_rd", RdE, 0);
    chk("lu_cnt", BubbleCnt, 1);
    chk("lu_stalld_off", StallD, 0);
    step();
    chk("lu_held_rd", RdE, 8);
    chk("lu_held_pc", PCE, 32'h104);
    chk("lu_held_rd1", RD1E, 32'h33);
    chk("lu_held_valid", ValidE, 1);
    chk("lu_held_stalld", StallD, 0);

    // 3: x0 and no match
    set_load(0);
    step();
    set_load(7);
    #1 chk("x0_nostall", StallD, 0);
    step();
    chk("x0_cap_rd", RdE, 7);
    set_alu(3, 4, 10, 32'h200);
    #1 chk("nomatch_nostall", StallD, 0);
    step();
    chk("nomatch_rd", RdE, 10);
    chk("nomatch_pc", PCE, 32'h200);
    chk("nomatch_cnt", BubbleCnt, 1);

    // 4: flush, then flush with load-use
    clear_d();
    MemWriteD = 1; Rs1D = 1; Rs2D = 2; ValidD = 1; PCD = 32'h204;
    FlushE = 1;
    step();
    FlushE = 0;
    chk("fl_memwrite", MemWriteE, 0);
    chk("fl_valid", ValidE, 0);
    chk("fl_cnt", BubbleCnt, 2);
    set_load(7);
    step();
    set_alu(0, 7, 9, 32'h300);
    FlushE = 1;
    #1 chk("fllu_stalld", StallD, 1);
    step();
    FlushE = 0;
    chk("fllu_valid", ValidE, 0);
    chk("fllu_cnt", BubbleCnt, 3);

    // 5: hold
    rst = 1;
    step();
    rst = 0;
    chk("rst2_cnt", BubbleCnt, 0);
    set_alu(1, 2, 11, 32'h300);
    step();
    StallE = 1;
    for (int i = 0; i < 3; i++) begin
      set_alu(5'(i), 5'(i + 1), 5'(12 + i), 32'h400 + DW'(i));
      #1 chk("hold_stalld", StallD, 1);
      step();
      chk("hold_rd", RdE, 11);
      chk("hold_pc", PCE, 32'h300);
      chk("hold_valid", ValidE, 1);
      chk("hold_cnt", BubbleCnt, 0);
    end
    FlushE = 1;
    step();
    FlushE = 0; StallE = 0;
    chk("holdfl_valid", ValidE, 0);
    chk("holdfl_rd", RdE, 0);
    chk("holdfl_cnt", BubbleCnt, 1);

    // ValidD low: captured fields, no bubble count
    set_alu(1, 2, 13, 32'h500);
    ValidD = 0;
    step();
    chk("vd0_valid", ValidE, 0);
    chk("vd0_rd", RdE, 13);
    chk("vd0_cnt", BubbleCnt, 1);

    // 6: saturation and mid-run reset
    rst = 1;
    step();
    rst = 0;
    FlushE = 1;
    for (int i = 0; i < 5; i++) begin
      logic [CW-1:0] exp_cnt;
      exp_cnt = (i < 3) ? CW'(i + 1) : 2'd3;
      step();
      chk("sat_cnt", BubbleCnt, exp_cnt);
    end
    FlushE = 0;
    set_alu(1, 2, 14, 32'h600);
    step();
    chk("mid_pre_valid", ValidE, 1);
    rst = 1; FlushE = 1;
    step();
    rst = 0; FlushE = 0;
    chk("mid_valid", ValidE, 0);
    chk("mid_rd", RdE, 0);
    chk("mid_pc", PCE, 0);
    chk("mid_regwrite", RegWriteE, 0);
    chk("mid_cnt", BubbleCnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
